// File: rtl/peak_frame_ctrl_if.sv
// Handshake and result bundle for peak_frame_ctrl: sample stream in, one
// held result out per frame. master = frame producer/consumer, slave = block.
interface peak_frame_ctrl_if #(
  parameter int N  = 16,
  parameter int IW = 6
);
  logic          start;
  logic          abort;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          busy;
  logic          out_valid;
  logic          out_ack;
  logic [N-1:0]  out_peak;
  logic [IW-1:0] out_index;
  logic [IW-1:0] out_count;
  logic          out_empty;

  modport master (
    output start, abort, in_valid, in_data, out_ack,
    input  in_ready, busy, out_valid, out_peak, out_index, out_count, out_empty
  );

  modport slave (
    input  start, abort, in_valid, in_data, out_ack,
    output in_ready, busy, out_valid, out_peak, out_index, out_count, out_empty
  );
endinterface

// File: rtl/peak_frame_ctrl.sv
// Captures K signed samples and reports the earliest largest non-negative one;
// result appears 1 cycle after the last transfer and is held until out_ack.
module peak_frame_ctrl #(
  parameter int N  = 16,
  parameter int K  = 42,
  parameter int IW = 6
) (
  input  logic            clk,
  input  logic            rst,
  peak_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, REPORT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, idx, pcnt;
  logic [IW-1:0] idx_nxt, pcnt_nxt;
  logic [N-1:0]  peak, peak_nxt;
  logic          found, found_nxt;
  logic          take, keep, last;

  assign bus.in_ready = (state == CAPTURE) && !bus.abort;
  assign bus.busy     = (state != IDLE);

  // Running result including the sample transferred this cycle, so the
  // final sample can be folded straight into the registered outputs.
  always_comb begin
    take      = bus.in_valid && bus.in_ready;
    keep      = take && !bus.in_data[N-1];
    last      = take && (cnt == IW'(K-1));
    peak_nxt  = peak;
    idx_nxt   = idx;
    pcnt_nxt  = pcnt;
    found_nxt = found;
    if (keep) begin
      pcnt_nxt  = pcnt + IW'(1);
      found_nxt = 1'b1;
      if (!found || (bus.in_data[N-2:0] > peak[N-2:0])) begin
        peak_nxt = bus.in_data;
        idx_nxt  = cnt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CAPTURE;
      CAPTURE: begin
        if (bus.abort)  state_nxt = IDLE;
        else if (last)  state_nxt = REPORT;
      end
      REPORT:  if (bus.out_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      idx           <= '0;
      pcnt          <= '0;
      peak          <= '0;
      found         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_peak  <= '0;
      bus.out_index <= '0;
      bus.out_count <= '0;
      bus.out_empty <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt   <= '0;
            idx   <= '0;
            pcnt  <= '0;
            peak  <= '0;
            found <= 1'b0;
          end
        end
        CAPTURE: begin
          if (bus.abort) begin
            cnt   <= '0;
            idx   <= '0;
            pcnt  <= '0;
            peak  <= '0;
            found <= 1'b0;
          end else if (take) begin
            cnt   <= cnt + IW'(1);
            idx   <= idx_nxt;
            pcnt  <= pcnt_nxt;
            peak  <= peak_nxt;
            found <= found_nxt;
            if (last) begin
              bus.out_peak  <= peak_nxt;
              bus.out_index <= idx_nxt;
              bus.out_count <= pcnt_nxt;
              bus.out_empty <= ~found_nxt;
              bus.out_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (bus.out_ack) bus.out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/peak_frame_ctrl.md
PEAK_FRAME_CTRL -- requirements
Module: peak_frame_ctrl

Interface
REQ-001 Parameter N, default 16, sample width in bits (signed two's complement).
REQ-002 Parameter K, default 42, samples per frame; legal range 2..63.
REQ-003 Parameter IW, default 6, index and count width; 2**IW SHALL exceed K.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; requests capture of a new frame.
REQ-007 abort  input  1  terminates the current frame with no result.
REQ-008 in_valid  input  1  in_data holds a sample.
REQ-009 in_data  input  N  signed sample.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 busy  output  1  state is not IDLE.
REQ-012 out_valid  output  1  result fields are valid and held.
REQ-013 out_ack  input  1  consumer accepts the result.
REQ-014 out_peak  output  N  largest non-negative sample in the frame.
REQ-015 out_index  output  IW  frame position (0..K-1) of out_peak.
REQ-016 out_count  output  IW  number of non-negative samples in the frame.
REQ-017 out_empty  output  1  frame contained no non-negative sample.

Function
REQ-018 The FSM SHALL have three states: IDLE, CAPTURE and REPORT.
REQ-019 IDLE: on start=1, go to CAPTURE; clear sample counter, running peak (0), index (0), count (0) and found flag.
REQ-020 CAPTURE: in_ready=1; a sample is transferred when in_valid=1 and in_ready=1.
REQ-021 Every transfer SHALL increment the sample counter, including transfers of negative samples.
REQ-022 A transfer with in_data[N-1]=0 SHALL increment count.
REQ-023 Such a transfer SHALL also replace peak and index when found=0 or in_data > peak (unsigned compare on N-1 bits), then set found=1.
REQ-024 Ties SHALL keep the earliest index.
REQ-025 A transfer with in_data[N-1]=1 SHALL be consumed without updating peak or index.
REQ-026 The transfer with counter value K-1 SHALL move the FSM to REPORT on the same edge.
REQ-027 Entering REPORT SHALL register out_peak, out_index, out_count and out_empty=~found, with the final sample included, and set out_valid=1 on the next cycle.
REQ-028 The capture latency from the last transfer to out_valid=1 SHALL be exactly 1 cycle.
REQ-029 REPORT: result fields SHALL stay stable while out_valid=1; in_ready=0.
REQ-030 out_ack=1 in REPORT SHALL clear out_valid and return to IDLE on that edge.
REQ-031 out_ack outside REPORT SHALL be ignored.
REQ-032 start SHALL be ignored in CAPTURE and REPORT.
REQ-033 start and out_ack in the same REPORT cycle SHALL return to IDLE only; the start SHALL NOT be queued.
REQ-034 abort=1 in CAPTURE SHALL return to IDLE, discard partial state and drop any same-cycle transfer (in_ready is forced to 0 that cycle).
REQ-035 abort=1 in REPORT or IDLE SHALL be ignored.
REQ-036 abort SHALL have priority over frame completion.
REQ-037 in_valid while in_ready=0 SHALL have no effect.
REQ-038 in_ready and busy SHALL be combinational decodes of state (and of abort for in_ready).
REQ-039 All other outputs SHALL be registered.
REQ-040 All-negative frame: out_peak=0, out_index=0, out_count=0, out_empty=1.

Reset
REQ-041 rst=1 SHALL immediately force IDLE, busy=0, in_ready=0 and out_valid=0.
REQ-042 rst=1 SHALL immediately force out_peak=0, out_index=0, out_count=0, out_empty=0 and clear all counters.
REQ-043 rst asserted mid-CAPTURE or in REPORT SHALL lose the frame; no result appears after release.
REQ-044 After rst deasserts, the block SHALL wait for a new start.

Verification (K=4 override unless noted)
REQ-045 Samples 5,9,3,9 with in_valid continuous -> out_valid one cycle after the 4th transfer; peak=9, index=1, count=4, empty=0.
REQ-046 Samples -1,-7,2,-3 -> peak=2, index=2, count=1, empty=0; samples -1,-2,-3,-4 -> peak=0, index=0, count=0, empty=1.
REQ-047 in_valid toggled 1,0,0,1,1,0,1 with samples 1,4,2,8 -> exactly 4 transfers; peak=8, index=3; out_valid only after the 4th.
REQ-048 abort asserted in the cycle of the 3rd transfer, then start and 10,20,30,40 -> the result reflects only the new frame: peak=40, index=3, count=4.
REQ-049 Hold out_ack=0 for 20 cycles in REPORT with start pulses -> outputs stable and no new frame; out_ack=1 -> IDLE next cycle.
REQ-050 rst pulse asynchronous to clk mid-CAPTURE (K=42) -> busy=0 and out_valid=0 before the next edge; no out_valid after release without start.
